risc_exec_unit: RTL and testbench
=================================

RISC_EXEC_UNIT -- requirements
Module: risc_exec_unit

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of the accumulator, memory data and ALU result.
REQ-002 Parameter ADDR_W, default 5, SHALL set the width of the program counter and the instruction address field.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_, input, 1 bit, SHALL be an asynchronous active-high reset; the name keeps the codebase spelling, but 1 means reset.
REQ-005 Port opcode, input, 3 bits, SHALL carry the current instruction opcode from the instruction register.
REQ-006 Port ir_addr, input, ADDR_W bits, SHALL carry the instruction operand address, used as the jump target.
REQ-007 Port accum, input, DATA_W bits, SHALL carry the current accumulator value.
REQ-008 Port data, input, DATA_W bits, SHALL carry the memory read data.
REQ-009 Port alu_out, output, DATA_W bits, SHALL be the registered ALU result.
REQ-010 Port zero, output, 1 bit, SHALL be combinational and equal 1 exactly when accum == 0.
REQ-011 Port pc_addr, output, ADDR_W bits, SHALL be the program counter value.
REQ-012 Ports mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt and fetch SHALL be 1-bit control outputs.
- Each control output SHALL be combinational from state, opcode and zero.

Function
REQ-013 Opcode encoding SHALL be:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-014 On every rising edge, alu_out SHALL register the result selected by opcode:
- ADD: accum+data, truncated to DATA_W with carry discarded (8'hFF+8'h01 gives 8'h00).
- AND: accum&data.
- XOR: accum^data.
- LDA: data.
- HLT, SKZ, STO, JMP: accum.
REQ-015 The sequencer SHALL be an 8-state FSM, states 0..7: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- Each state SHALL advance to the next every clock.
- STORE SHALL advance to INST_ADDR.
REQ-016 While opcode==HLT in OP_ADDR, the FSM SHALL stay in OP_ADDR until reset.
REQ-017 Define ALUOP = opcode in {ADD, AND, XOR, LDA}. Every control output SHALL be 0 unless it is set by the per-state rules below.
REQ-018 Per-state control outputs SHALL be:
- INST_ADDR: fetch=1.
- INST_FETCH: fetch=1, mem_rd=1.
- INST_LOAD: fetch=1, mem_rd=1, load_ir=1.
- IDLE: fetch=1, mem_rd=1, load_ir=1.
- OP_ADDR: halt=(opcode==HLT); inc_pc=(opcode!=HLT).
- OP_FETCH: mem_rd=ALUOP.
- ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(opcode==SKZ && zero), load_pc=(opcode==JMP).
- STORE: mem_rd=ALUOP, load_ac=ALUOP, mem_wr=(opcode==STO), inc_pc=(opcode==JMP), load_pc=(opcode==JMP).
REQ-019 The PC SHALL update on the rising edge:
- if load_pc=1, pc_addr <= ir_addr;
- else if inc_pc=1, pc_addr <= pc_addr+1, wrapping from 2^ADDR_W-1 to 0;
- otherwise it holds.
REQ-020 When load_pc and inc_pc are both 1 (JMP in STORE), load_pc SHALL take priority and pc_addr <= ir_addr.
REQ-021 A normal instruction SHALL take 8 clocks and advance pc_addr by exactly 1; a SKZ with accum==0 SHALL advance it by 2.

Reset
REQ-022 While rst_=1, and immediately on its assertion at any point in an instruction, the outputs SHALL be:
- state=INST_ADDR;
- pc_addr=0;
- alu_out=0.
Control outputs therefore take their INST_ADDR values: fetch=1, all others 0.
REQ-023 After rst_ deasserts, the first rising edge SHALL move the FSM to INST_FETCH.

Verification
REQ-024 Reset mid-ALU_OP -> the response is:
- state=INST_ADDR, pc_addr=0 and alu_out=0 asynchronously;
- fetch=1 and every other control output 0.
REQ-025 opcode=ADD, accum=8'h0F, data=8'h01 -> the following edge gives alu_out=8'h10.
- In ALU_OP: load_ac=1 and mem_rd=1.
- pc_addr advances by 1 per 8 clocks.
REQ-026 opcode=SKZ, accum=0 -> in ALU_OP, inc_pc=1.
- pc_addr advances by 2 over the instruction.
- With accum=8'h01 it advances by 1.
REQ-027 opcode=JMP, ir_addr=5'h13, pc_addr=5'h02 -> pc_addr=5'h13 after ALU_OP and after STORE.
REQ-028 opcode=STO -> mem_wr=1 only in STORE, with mem_rd=0 there.
- opcode=HLT -> halt=1 from OP_ADDR onward; the FSM and pc_addr stay frozen.
REQ-029 PC wrap -> pc_addr=5'h1F plus an increment gives 5'h00.

Source files
------------

// File: rtl/risc_exec_unit.sv
// Execution core of a small accumulator machine: 8-phase instruction sequencer,
// registered ALU and program counter.
module risc_exec_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic [DATA_W-1:0] accum,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              load_ir,
    output logic              load_ac,
    output logic              inc_pc,
    output logic              load_pc,
    output logic              halt,
    output logic              fetch
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                is_aluop;

    assign zero     = (accum == '0);
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    // Sequencer: one phase per clock; a halt parks the machine in OP_ADDR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INST_ADDR:  state_d = INST_FETCH;
            INST_FETCH: state_d = INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode == OP_HLT) ? OP_ADDR : OP_FETCH;
            OP_FETCH:   state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE:      state_d = INST_ADDR;
            default:    state_d = INST_ADDR;
        endcase
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        halt    = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            INST_ADDR: begin
                fetch = 1'b1;
            end
            INST_FETCH: begin
                fetch  = 1'b1;
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                fetch   = 1'b1;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                halt   = (opcode == OP_HLT);
                inc_pc = (opcode != OP_HLT);
            end
            OP_FETCH: begin
                mem_rd = is_aluop;
            end
            ALU_OP: begin
                mem_rd  = is_aluop;
                load_ac = is_aluop;
                inc_pc  = (opcode == OP_SKZ) && zero;
                load_pc = (opcode == OP_JMP);
            end
            STORE: begin
                mem_rd  = is_aluop;
                load_ac = is_aluop;
                mem_wr  = (opcode == OP_STO);
                inc_pc  = (opcode == OP_JMP);
                load_pc = (opcode == OP_JMP);
            end
            default: begin
                fetch = 1'b1;
            end
        endcase
    end

    // A jump target wins over an increment when both are requested.
    always_comb begin
        pc_d = pc_q;
        if (load_pc) begin
            pc_d = ir_addr;
        end else if (inc_pc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        alu_d = accum;
        case (opcode)
            OP_ADD:  alu_d = accum + data;
            OP_AND:  alu_d = accum & data;
            OP_XOR:  alu_d = accum ^ data;
            OP_LDA:  alu_d = data;
            default: alu_d = accum;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= INST_ADDR;
            pc_q    <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            alu_q   <= alu_d;
        end
    end

    assign pc_addr = pc_q;
    assign alu_out = alu_q;

endmodule

// File: tb/tb_risc_exec_unit.sv
// Directed bench for risc_exec_unit: walks whole instructions phase by phase
// and checks control outputs, PC and ALU result against hand-computed values.
module tb_risc_exec_unit;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic [4:0] ir_addr;
    logic [7:0] accum;
    logic [7:0] data;
    logic [7:0] alu_out;
    logic       zero;
    logic [4:0] pc_addr;
    logic       mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, fetch;
    logic [7:0] ctrl;

    int n_cmp = 0;
    int n_err = 0;

    risc_exec_unit #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .ir_addr (ir_addr),
        .accum   (accum),
        .data    (data),
        .alu_out (alu_out),
        .zero    (zero),
        .pc_addr (pc_addr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .inc_pc  (inc_pc),
        .load_pc (load_pc),
        .halt    (halt),
        .fetch   (fetch)
    );

    // Bit order: mem_rd mem_wr load_ir load_ac inc_pc load_pc halt fetch
    assign ctrl = {mem_rd, mem_wr, load_ir, load_ac, inc_pc, load_pc, halt, fetch};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full instruction from INST_ADDR back to INST_ADDR.
    task automatic run_instr(input string name, input logic [2:0] op,
                             input logic [7:0] acc, input logic [7:0] dat,
                             input logic [4:0] ira, input logic exp_zero,
                             input logic [7:0] c_opaddr, input logic [7:0] c_opfetch,
                             input logic [7:0] c_aluop, input logic [7:0] c_store,
                             input logic [4:0] pc_store, input logic [4:0] pc_end,
                             input logic [7:0] exp_alu);
        opcode  = op;
        accum   = acc;
        data    = dat;
        ir_addr = ira;
        #1;
        chk({name, ".zero"}, 32'(zero), 32'(exp_zero));
        chk({name, ".ctl_inst_addr"}, 32'(ctrl), 32'h01);
        tick();
        chk({name, ".ctl_inst_fetch"}, 32'(ctrl), 32'h81);
        tick();
        chk({name, ".ctl_inst_load"}, 32'(ctrl), 32'hA1);
        tick();
        chk({name, ".ctl_idle"}, 32'(ctrl), 32'hA1);
        tick();
        chk({name, ".ctl_op_addr"}, 32'(ctrl), 32'(c_opaddr));
        tick();
        chk({name, ".ctl_op_fetch"}, 32'(ctrl), 32'(c_opfetch));
        tick();
        chk({name, ".ctl_alu_op"}, 32'(ctrl), 32'(c_aluop));
        tick();
        chk({name, ".ctl_store"}, 32'(ctrl), 32'(c_store));
        chk({name, ".pc_in_store"}, 32'(pc_addr), 32'(pc_store));
        tick();
        chk({name, ".pc_end"}, 32'(pc_addr), 32'(pc_end));
        chk({name, ".alu_out"}, 32'(alu_out), 32'(exp_alu));
        $display("instr %s op=%0d acc=%02h data=%02h -> pc=%02h alu_out=%02h",
                 name, op, acc, dat, pc_addr, alu_out);
    endtask

    initial begin
        rst_    = 1'b1;
        opcode  = 3'd0;
        ir_addr = 5'd0;
        accum   = 8'h00;
        data    = 8'h00;
        @(negedge clk);
        chk("reset.pc", 32'(pc_addr), 32'h00);
        chk("reset.alu", 32'(alu_out), 32'h00);
        chk("reset.ctl", 32'(ctrl), 32'h01);
        rst_ = 1'b0;

        //        name        op    acc    data   ira    z     opaddr opfetch aluop store pcS    pcE    alu
        run_instr("add",      3'd2, 8'h0F, 8'h01, 5'h00, 1'b0, 8'h08, 8'h80, 8'h90, 8'h90, 5'h01, 5'h01, 8'h10);
        run_instr("add_wrap", 3'd2, 8'hFF, 8'h01, 5'h00, 1'b0, 8'h08, 8'h80, 8'h90, 8'h90, 5'h02, 5'h02, 8'h00);
        run_instr("and",      3'd3, 8'hF0, 8'h3C, 5'h00, 1'b0, 8'h08, 8'h80, 8'h90, 8'h90, 5'h03, 5'h03, 8'h30);
        run_instr("xor",      3'd4, 8'hF0, 8'h3C, 5'h00, 1'b0, 8'h08, 8'h80, 8'h90, 8'h90, 5'h04, 5'h04, 8'hCC);
        run_instr("lda",      3'd5, 8'h00, 8'h5A, 5'h00, 1'b1, 8'h08, 8'h80, 8'h90, 8'h90, 5'h05, 5'h05, 8'h5A);
        run_instr("skz_take", 3'd1, 8'h00, 8'hA5, 5'h00, 1'b1, 8'h08, 8'h00, 8'h08, 8'h00, 5'h07, 5'h07, 8'h00);
        run_instr("skz_no",   3'd1, 8'h01, 8'hA5, 5'h00, 1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 5'h08, 5'h08, 8'h01);
        run_instr("sto",      3'd6, 8'h33, 8'h77, 5'h00, 1'b0, 8'h08, 8'h00, 8'h00, 8'h40, 5'h09, 5'h09, 8'h33);
        run_instr("jmp",      3'd7, 8'h44, 8'h00, 5'h13, 1'b0, 8'h08, 8'h00, 8'h04, 8'h0C, 5'h13, 5'h13, 8'h44);
        run_instr("jmp_top",  3'd7, 8'h44, 8'h00, 5'h1F, 1'b0, 8'h08, 8'h00, 8'h04, 8'h0C, 5'h1F, 5'h1F, 8'h44);
        run_instr("pc_wrap",  3'd2, 8'h01, 8'h01, 5'h00, 1'b0, 8'h08, 8'h80, 8'h90, 8'h90, 5'h00, 5'h00, 8'h02);

        // Asynchronous reset in the middle of ALU_OP.
        opcode = 3'd2;
        accum  = 8'h0F;
        data   = 8'h01;
        repeat (6) tick();
        chk("midrst.pre_ctl", 32'(ctrl), 32'h90);
        chk("midrst.pre_pc", 32'(pc_addr), 32'h01);
        chk("midrst.pre_alu", 32'(alu_out), 32'h10);
        #2 rst_ = 1'b1;
        #1;
        chk("midrst.pc", 32'(pc_addr), 32'h00);
        chk("midrst.alu", 32'(alu_out), 32'h00);
        chk("midrst.ctl", 32'(ctrl), 32'h01);
        $display("reset asserted mid ALU_OP -> pc=%02h alu_out=%02h ctrl=%02h", pc_addr, alu_out, ctrl);
        @(negedge clk);
        rst_ = 1'b0;
        tick();
        chk("postrst.ctl_inst_fetch", 32'(ctrl), 32'h81);

        // Halt: the machine must freeze in OP_ADDR.
        opcode = 3'd0;
        accum  = 8'h21;
        tick();
        tick();
        tick();
        chk("hlt.ctl_op_addr", 32'(ctrl), 32'h02);
        chk("hlt.pc", 32'(pc_addr), 32'h00);
        repeat (5) tick();
        chk("hlt.ctl_frozen", 32'(ctrl), 32'h02);
        chk("hlt.pc_frozen", 32'(pc_addr), 32'h00);
        chk("hlt.alu", 32'(alu_out), 32'h21);
        $display("instr hlt -> pc=%02h ctrl=%02h", pc_addr, ctrl);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
